// File: rtl/tb_run_ctrl.sv
// tb_run_ctrl: simulation run controller for the tinyriscv system bench.
// Sequences the core reset, counts run cycles and retired instructions,
// and ends the run on a tohost mailbox write or a cycle-budget watchdog.
module tb_run_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32,
    parameter int RST_CYCLES = 2,
    parameter int MAX_CYCLES = 800,
    parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR = ADDR_WIDTH'(32'h0000_1000)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_we,
    input  logic [ADDR_WIDTH-1:0] mem_waddr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  retire,
    output logic                  core_rst,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic [DATA_WIDTH-2:0] fail_code,
    output logic [CNT_WIDTH-1:0]  cycle_cnt,
    output logic [CNT_WIDTH-1:0]  retire_cnt
);

    localparam int HW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [HW-1:0]        HOLD_LAST = HW'(RST_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] WD_LAST   = CNT_WIDTH'(MAX_CYCLES - 1);

    typedef enum logic [2:0] {
        S_HOLD = 3'd0,
        S_RUN  = 3'd1,
        S_PASS = 3'd2,
        S_FAIL = 3'd3,
        S_TMO  = 3'd4
    } state_t;

    state_t          state;
    logic [HW-1:0]   hold_cnt;
    logic            term_wr;

    // A mailbox write only ends the run when its low bit is set.
    assign term_wr = mem_we && (mem_waddr == TOHOST_ADDR) && mem_wdata[0];

    // Run FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_HOLD;
            hold_cnt   <= '0;
            core_rst   <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            timeout    <= 1'b0;
            fail_code  <= '0;
            cycle_cnt  <= '0;
            retire_cnt <= '0;
        end else begin
            case (state)
                S_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state    <= S_RUN;
                        core_rst <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    // The terminating or expiring cycle is still counted.
                    if (cycle_cnt != '1)
                        cycle_cnt <= cycle_cnt + 1'b1;
                    if (retire && (retire_cnt != '1))
                        retire_cnt <= retire_cnt + 1'b1;
                    // A terminating write beats a same-cycle watchdog expiry.
                    if (term_wr) begin
                        done     <= 1'b1;
                        core_rst <= 1'b0;
                        if (mem_wdata == DATA_WIDTH'(1)) begin
                            state <= S_PASS;
                            pass  <= 1'b1;
                        end else begin
                            state     <= S_FAIL;
                            fail_code <= mem_wdata[DATA_WIDTH-1:1];
                        end
                    end else if (cycle_cnt == WD_LAST) begin
                        state    <= S_TMO;
                        done     <= 1'b1;
                        timeout  <= 1'b1;
                        core_rst <= 1'b0;
                    end
                end
                default: begin
                    // Terminal states hold everything until rst.
                    state <= state;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tb_run_ctrl.sv
// Self-checking bench for tb_run_ctrl: a vector table for reset/hold/pass,
// plus hand sequences for fail, timeout, collision and mid-run reset.
module tb_tb_run_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_we;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic        retire;
    logic        core_rst, done, pass, timeout;
    logic [30:0] fail_code;
    logic [31:0] cycle_cnt, retire_cnt;

    int checks = 0;
    int passed = 0;

    tb_run_ctrl #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .CNT_WIDTH(32),
        .RST_CYCLES(2), .MAX_CYCLES(16), .TOHOST_ADDR(32'h0000_1000)
    ) dut (
        .clk(clk), .rst(rst), .mem_we(mem_we), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .retire(retire), .core_rst(core_rst),
        .done(done), .pass(pass), .timeout(timeout), .fail_code(fail_code),
        .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, we;
        logic [31:0] addr, wdata;
        logic        ret;
        logic        cr, d, p, t;
        logic [30:0] fc;
        logic [31:0] cc, rc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic we, input logic [31:0] a,
                                input logic [31:0] wd, input logic rt, input logic cr,
                                input logic d, input logic p, input logic t,
                                input logic [30:0] fc, input logic [31:0] cc,
                                input logic [31:0] rc);
        vec_t v;
        v.rst = r; v.we = we; v.addr = a; v.wdata = wd; v.ret = rt;
        v.cr = cr; v.d = d; v.p = p; v.t = t; v.fc = fc; v.cc = cc; v.rc = rc;
        return v;
    endfunction

    // Sample #1 after the active edge; inputs stay as set before the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic cr, input logic d, input logic p,
                       input logic t, input logic [30:0] fc, input logic [31:0] cc,
                       input logic [31:0] rc);
        checks++;
        if (core_rst === cr && done === d && pass === p && timeout === t &&
            fail_code === fc && cycle_cnt === cc && retire_cnt === rc) begin
            passed++;
        end else begin
            $display("FAIL %s: got cr=%b d=%b p=%b t=%b fc=%0d cc=%0d rc=%0d, want cr=%b d=%b p=%b t=%b fc=%0d cc=%0d rc=%0d",
                     nm, core_rst, done, pass, timeout, fail_code, cycle_cnt, retire_cnt,
                     cr, d, p, t, fc, cc, rc);
        end
    endtask

    task automatic idle();
        mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0; retire = 1'b0;
    endtask

    // Reset one cycle, then release through the two HOLD edges into RUN.
    task automatic restart();
        idle();
        rst = 1'b0; step();
        rst = 1'b1; step();
        step();
        chk("restart_run", 1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic run_n(input int n, input logic rt);
        retire = rt;
        for (int i = 0; i < n; i++) step();
        retire = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        mem_we = 1'b1; mem_waddr = a; mem_wdata = d;
    endtask

    initial begin
        rst = 1'b0;
        idle();

        // Reset (3 cycles), hold (2 edges), 10 RUN cycles with 7 retires
        // and two ignored writes, then a pass write on RUN cycle 11.
        tbl.push_back(mk(0,0,0,0,1, 0,0,0,0,0, 0,0));
        tbl.push_back(mk(0,1,32'h1000,1,1, 0,0,0,0,0, 0,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0, 0,0));
        tbl.push_back(mk(1,0,0,0,1, 0,0,0,0,0, 0,0));
        tbl.push_back(mk(1,1,32'h1000,1,1, 1,0,0,0,0, 0,0));
        tbl.push_back(mk(1,0,0,0,1,            1,0,0,0,0, 1,1));
        tbl.push_back(mk(1,0,0,0,1,            1,0,0,0,0, 2,2));
        tbl.push_back(mk(1,1,32'h1000,32'h4,0, 1,0,0,0,0, 3,2));
        tbl.push_back(mk(1,0,0,0,1,            1,0,0,0,0, 4,3));
        tbl.push_back(mk(1,1,32'h1004,32'h1,1, 1,0,0,0,0, 5,4));
        tbl.push_back(mk(1,0,0,0,0,            1,0,0,0,0, 6,4));
        tbl.push_back(mk(1,0,0,0,1,            1,0,0,0,0, 7,5));
        tbl.push_back(mk(1,0,0,0,1,            1,0,0,0,0, 8,6));
        tbl.push_back(mk(1,0,0,0,0,            1,0,0,0,0, 9,6));
        tbl.push_back(mk(1,0,0,0,1,            1,0,0,0,0, 10,7));
        tbl.push_back(mk(1,1,32'h1000,32'h1,0, 0,1,1,0,0, 11,7));
        tbl.push_back(mk(1,1,32'h1000,32'h2B,1, 0,1,1,0,0, 11,7));

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst; mem_we = tbl[i].we; mem_waddr = tbl[i].addr;
            mem_wdata = tbl[i].wdata; retire = tbl[i].ret;
            step();
            chk($sformatf("vec%0d", i), tbl[i].cr, tbl[i].d, tbl[i].p, tbl[i].t,
                tbl[i].fc, tbl[i].cc, tbl[i].rc);
        end

        // Terminal PASS stays frozen for 20 more cycles under busy inputs.
        for (int i = 0; i < 20; i++) begin
            retire = 1'b1;
            wr(32'h1000, (i % 2 == 0) ? 32'h3 : 32'h1);
            step();
        end
        idle();
        chk("pass_frozen", 0, 1, 1, 0, 0, 11, 7);

        // Fail code: 0x2B -> code 21; retire on the terminating cycle counts.
        restart();
        run_n(3, 1'b0);
        wr(32'h1000, 32'h0000_002B); retire = 1'b1;
        step();
        idle();
        chk("fail_code", 0, 1, 0, 0, 31'd21, 4, 1);
        run_n(5, 1'b1);
        chk("fail_frozen", 0, 1, 0, 0, 31'd21, 4, 1);

        // Watchdog: 15 cycles still running, 16th edge times out.
        restart();
        run_n(15, 1'b1);
        chk("tmo_edge15", 1, 0, 0, 0, 0, 15, 15);
        run_n(1, 1'b1);
        chk("tmo_edge16", 0, 1, 0, 1, 0, 16, 16);
        run_n(3, 1'b1);
        chk("tmo_frozen", 0, 1, 0, 1, 0, 16, 16);

        // Collision: pass write in RUN cycle 16 wins over the watchdog.
        restart();
        run_n(15, 1'b0);
        wr(32'h1000, 32'h1);
        step();
        idle();
        chk("collision", 0, 1, 1, 0, 0, 16, 0);

        // Mid-run reset in RUN cycle 5, then normal HOLD->RUN again.
        restart();
        run_n(4, 1'b1);
        chk("mid_pre", 1, 0, 0, 0, 0, 4, 4);
        rst = 1'b0; retire = 1'b1;
        step();
        chk("mid_rst", 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        step();
        chk("mid_hold1", 0, 0, 0, 0, 0, 0, 0);
        step();
        chk("mid_hold2", 1, 0, 0, 0, 0, 0, 0);
        step();
        chk("mid_run1", 1, 0, 0, 0, 0, 1, 1);
        retire = 1'b0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
